// File: rtl/sort_top.sv
// ---------------------------------------------------------------------------
// sort_top : in-place ascending selection sorter over a small flop-array RAM
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sort_top #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] Radd,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  wrin,
  output logic [DATA_WIDTH-1:0] dataout
);

  localparam int                  c_n       = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_last  = ADDR_WIDTH'(c_n - 1);
  localparam logic [ADDR_WIDTH-1:0] c_penult = ADDR_WIDTH'(c_n - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    CMP    = 3'd2,
    NEXT_I = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d;
  logic [ADDR_WIDTH-1:0] j_q, j_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [c_n];
  logic [DATA_WIDTH-1:0] mem_d [c_n];

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        // start wins over a coincident host write
        if (s) begin
          i_d     = '0;
          state_d = LOAD_A;
        end else if (wrin) begin
          mem_d[Radd] = datain;
        end
      end
      LOAD_A: begin
        a_d     = mem_q[i_q];
        j_d     = i_q + 1'b1;
        state_d = CMP;
      end
      CMP: begin
        // A always tracks the current minimum sitting at mem[i]
        if (mem_q[j_q] < a_q) begin
          mem_d[i_q] = mem_q[j_q];
          mem_d[j_q] = a_q;
          a_d        = mem_q[j_q];
        end
        if (j_q == c_last) begin
          state_d = NEXT_I;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      NEXT_I: begin
        if (i_q == c_penult) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = LOAD_A;
        end
      end
      DONE: begin
        if (!s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < c_n; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      done_q  <= done_d;
      for (int k = 0; k < c_n; k++) mem_q[k] <= mem_d[k];
    end
  end

  assign done    = done_q;
  assign dataout = mem_q[Radd];

endmodule

`default_nettype wire

// File: tb/tb_sort_top.sv
// ---------------------------------------------------------------------------
// tb_sort_top : self-checking bench for sort_top (vector table + random model)
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sort_top;

  logic       clk;
  logic       rstn;
  logic       s;
  logic       done;
  logic [2:0] Radd;
  logic [7:0] datain;
  logic       wrin;
  logic [7:0] dataout;

  int checks = 0;
  int errors = 0;

  sort_top #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s      (s),
    .done   (done),
    .Radd   (Radd),
    .datain (datain),
    .wrin   (wrin),
    .dataout(dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byte k of a 64-bit word holds address k
  typedef struct {
    logic [63:0] din;
    logic [63:0] exp;
    bit          hold_wr;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rank-based reference: each word lands at (#smaller + #equal-with-lower-address)
  function automatic logic [63:0] ref_sort(input logic [63:0] d);
    logic [63:0] r;
    int          rank;
    r = '0;
    for (int a = 0; a < 8; a++) begin
      rank = 0;
      for (int b = 0; b < 8; b++)
        if (d[8*b +: 8] < d[8*a +: 8] || (d[8*b +: 8] == d[8*a +: 8] && b < a)) rank++;
      r[8*rank +: 8] = d[8*a +: 8];
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b1; s = 1'b0; wrin = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic write_all(input logic [63:0] d);
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      Radd = 3'(a); datain = d[8*a +: 8]; wrin = 1'b1;
    end
    @(negedge clk);
    wrin = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [63:0] exp);
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      Radd = 3'(a);
      #1;
      chk($sformatf("%s[%0d]", tag, a), 32'(dataout), 32'(exp[8*a +: 8]));
    end
  endtask

  task automatic run_sort(input bit hold_wr);
    int cnt;
    bit seen;
    @(negedge clk);
    s = 1'b1;
    if (hold_wr) begin
      wrin = 1'b1; datain = 8'h33; Radd = 3'd0;
    end
    @(posedge clk);
    cnt = 0; seen = 0;
    while (!seen && cnt < 100) begin
      @(posedge clk);
      cnt++;
      #1;
      if (done) seen = 1;
    end
    chk("latency", 32'(cnt), 32'd42);
  endtask

  task automatic end_sort();
    @(negedge clk);
    wrin = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_held", 32'(done), 32'd1);
    s = 1'b0;
    @(posedge clk);
    #1;
    chk("done_drop", 32'(done), 32'd0);
  endtask

  initial begin
    logic [63:0] d;
    rstn = 1'b1; s = 1'b0; wrin = 1'b0; Radd = '0; datain = '0;

    vecs[0] = '{din: 64'h00000000_A3A2A1A0, exp: 64'hA3A2A1A0_00000000, hold_wr: 1'b0};
    vecs[1] = '{din: 64'h00102030_40506070, exp: 64'h70605040_30201000, hold_wr: 1'b0};
    vecs[2] = '{din: 64'h8001FF80_0005FF05, exp: 64'hFFFF8080_05050100, hold_wr: 1'b0};
    vecs[3] = '{din: 64'h8001FF80_0005FF05, exp: 64'hFFFF8080_05050100, hold_wr: 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("reset_done", 32'(done), 32'd0);
    read_chk("reset_mem", 64'h0);

    // directed vectors
    for (int v = 0; v < 4; v++) begin
      do_reset();
      write_all(vecs[v].din);
      run_sort(vecs[v].hold_wr);
      read_chk($sformatf("vec%0d", v), vecs[v].exp);
      end_sort();
    end

    // reset mid-sort aborts and clears everything
    write_all(64'h0123456789ABCDEF);
    @(negedge clk);
    s = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1; s = 1'b0;
    #1;
    chk("abort_done", 32'(done), 32'd0);
    read_chk("abort_mem", 64'h0);
    @(negedge clk);
    rstn = 1'b0;
    write_all(64'h0123456789ABCDEF);
    run_sort(1'b0);
    read_chk("after_abort", ref_sort(64'h0123456789ABCDEF));
    end_sort();

    // random data against the reference model
    for (int t = 0; t < 10; t++) begin
      d = {$urandom(), $urandom()};
      if (t % 3 == 0) d[31:0] = d[63:32];
      write_all(d);
      run_sort(t[0]);
      read_chk($sformatf("rand%0d", t), ref_sort(d));
      end_sort();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
